// File: rtl/sc_level_tick_scheduler_if.sv
// Game-controller <-> tick-scheduler bus: run control, level/timer load,
// move request/ack handshake and status outputs.
interface sc_level_tick_scheduler_if #(
  parameter int TIMER_W = 8
) ();
  logic               start_InLow;
  logic               stop_InLow;
  logic [1:0]         level_InBUS;
  logic [TIMER_W-1:0] timerLoad_InBUS;
  logic               moveAck_InLow;
  logic               moveReq_OutLow;
  logic               timerDone_OutLow;
  logic [TIMER_W-1:0] timer_OutBUS;
  logic [1:0]         state_OutBUS;
  logic [3:0]         overrun_OutBUS;

  modport master (
    output start_InLow, stop_InLow, level_InBUS, timerLoad_InBUS, moveAck_InLow,
    input  moveReq_OutLow, timerDone_OutLow, timer_OutBUS, state_OutBUS, overrun_OutBUS
  );

  modport slave (
    input  start_InLow, stop_InLow, level_InBUS, timerLoad_InBUS, moveAck_InLow,
    output moveReq_OutLow, timerDone_OutLow, timer_OutBUS, state_OutBUS, overrun_OutBUS
  );
endinterface

// File: rtl/sc_level_tick_scheduler.sv
// Round countdown and level-paced move-request scheduler for the car game.
// Optional missed-move counter built only when SC_LEVEL_TICK_SCHEDULER_OVERRUN_EN is defined.
module sc_level_tick_scheduler #(
  parameter int TICK_DIV   = 12500000,
  parameter int SEC_TICKS  = 4,
  parameter int LVL1_TICKS = 8,
  parameter int LVL2_TICKS = 4,
  parameter int LVL3_TICKS = 2,
  parameter int TIMER_W    = 8
) (
  input  logic                        SC_LEVEL_TICK_SCHEDULER_CLOCK_50,
  input  logic                        SC_LEVEL_TICK_SCHEDULER_RESET_InLow,
  sc_level_tick_scheduler_if.slave    bus_if
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW   = (SEC_TICKS > 1) ? $clog2(SEC_TICKS) : 1;
  localparam int MAXP = (LVL1_TICKS > LVL2_TICKS)
                        ? ((LVL1_TICKS > LVL3_TICKS) ? LVL1_TICKS : LVL3_TICKS)
                        : ((LVL2_TICKS > LVL3_TICKS) ? LVL2_TICKS : LVL3_TICKS);
  localparam int MW   = $clog2(MAXP + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_LAST   = SW'(SEC_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  logic               clk;
  logic [1:0]         rst_sync_q;
  logic               rst_n_int;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               done_q, done_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [SW-1:0]      sec_q, sec_d;
  logic [MW-1:0]      move_q, move_d;

  logic               active, base_tick, sec_wrap, expiry, move_due;
  logic [MW-1:0]      period_last;

  assign clk = SC_LEVEL_TICK_SCHEDULER_CLOCK_50;

  // Reset asserts immediately but releases only after two clean edges.
  always_ff @(posedge clk or negedge SC_LEVEL_TICK_SCHEDULER_RESET_InLow) begin
    if (!SC_LEVEL_TICK_SCHEDULER_RESET_InLow) rst_sync_q <= 2'b00;
    else                                      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  always_comb begin
    unique case (bus_if.level_InBUS)
      2'b10:   period_last = MW'(LVL2_TICKS - 1);
      2'b11:   period_last = MW'(LVL3_TICKS - 1);
      default: period_last = MW'(LVL1_TICKS - 1);
    endcase
  end

  assign active    = (state_q == S_RUN) || (state_q == S_WAIT);
  assign base_tick = active && (presc_q == PRESC_LAST);
  assign sec_wrap  = base_tick && (sec_q == SEC_LAST);
  assign expiry    = sec_wrap && (timer_q <= TIMER_W'(1));
  assign move_due  = base_tick && (move_q >= period_last);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    done_d  = 1'b1;
    timer_d = timer_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    move_d  = move_q;

    if (active) begin
      presc_d = base_tick ? '0 : presc_q + PW'(1);
      if (base_tick) begin
        sec_d  = sec_wrap ? '0 : sec_q + SW'(1);
        move_d = move_due ? '0 : move_q + MW'(1);
      end
      if (sec_wrap && (timer_q != '0)) timer_d = timer_q - TIMER_W'(1);
    end

    if (!bus_if.stop_InLow) begin
      state_d = S_IDLE;
      req_d   = 1'b1;
      timer_d = timer_q;
      presc_d = '0;
      sec_d   = '0;
      move_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          presc_d = '0;
          sec_d   = '0;
          move_d  = '0;
          if (!bus_if.start_InLow) begin
            timer_d = bus_if.timerLoad_InBUS;
            if (bus_if.timerLoad_InBUS == '0) begin
              done_d  = 1'b0;
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
            end
          end
        end
        S_RUN, S_WAIT: begin
          // Expiry outranks both a returning ack and a due move.
          if (expiry) begin
            done_d  = 1'b0;
            req_d   = 1'b1;
            state_d = S_DONE;
            timer_d = '0;
            presc_d = '0;
            sec_d   = '0;
            move_d  = '0;
          end else if ((state_q == S_WAIT) && !bus_if.moveAck_InLow) begin
            req_d   = 1'b1;
            state_d = S_RUN;
          end else if ((state_q == S_RUN) && move_due) begin
            req_d   = 1'b0;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= S_IDLE;
      req_q   <= 1'b1;
      done_q  <= 1'b1;
      timer_q <= '0;
      presc_q <= '0;
      sec_q   <= '0;
      move_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      done_q  <= done_d;
      timer_q <= timer_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      move_q  <= move_d;
    end
  end

  assign bus_if.state_OutBUS     = state_q;
  assign bus_if.moveReq_OutLow   = req_q;
  assign bus_if.timerDone_OutLow = done_q;
  assign bus_if.timer_OutBUS     = timer_q;

`ifdef SC_LEVEL_TICK_SCHEDULER_OVERRUN_EN
  logic [3:0] ovr_q, ovr_d;

  // A due move that arrives while still waiting for ack is counted as missed.
  always_comb begin
    ovr_d = ovr_q;
    if (bus_if.stop_InLow) begin
      if (((state_q == S_IDLE) || (state_q == S_DONE)) && !bus_if.start_InLow)
        ovr_d = '0;
      else if ((state_q == S_WAIT) && move_due && !expiry && (ovr_q != 4'hF))
        ovr_d = ovr_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) ovr_q <= '0;
    else            ovr_q <= ovr_d;
  end

  assign bus_if.overrun_OutBUS = ovr_q;
`else
  assign bus_if.overrun_OutBUS = 4'b0000;
`endif

endmodule

// File: tb/tb_sc_level_tick_scheduler.sv
// Bench for sc_level_tick_scheduler: directed scenarios plus randomized run
// against a cycle-level reference model of the scheduling rules.
module tb_sc_level_tick_scheduler;

  localparam int TD = 4, ST = 2, L1 = 4, L2 = 2, L3 = 1, TW = 8;
`ifdef SC_LEVEL_TICK_SCHEDULER_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  sc_level_tick_scheduler_if #(.TIMER_W(TW)) bus_if ();

  sc_level_tick_scheduler #(
    .TICK_DIV(TD), .SEC_TICKS(ST), .LVL1_TICKS(L1), .LVL2_TICKS(L2),
    .LVL3_TICKS(L3), .TIMER_W(TW)
  ) dut (
    .SC_LEVEL_TICK_SCHEDULER_CLOCK_50   (clk),
    .SC_LEVEL_TICK_SCHEDULER_RESET_InLow(rst_n),
    .bus_if                             (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {state, moveReq, timerDone, timer, overrun}
  function automatic logic [15:0] dut_outs();
    return {bus_if.state_OutBUS, bus_if.moveReq_OutLow, bus_if.timerDone_OutLow,
            bus_if.timer_OutBUS, bus_if.overrun_OutBUS};
  endfunction

  task automatic start_run(input logic [1:0] lvl, input logic [7:0] load);
    bus_if.level_InBUS     = lvl;
    bus_if.timerLoad_InBUS = load;
    bus_if.start_InLow     = 1'b0;
    tick();
    bus_if.start_InLow     = 1'b1;
  endtask

  task automatic stop_to_idle();
    bus_if.stop_InLow = 1'b0;
    tick();
    bus_if.stop_InLow = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    bus_if.start_InLow = 1'b1; bus_if.stop_InLow = 1'b1; bus_if.moveAck_InLow = 1'b1;
    bus_if.level_InBUS = 2'b01; bus_if.timerLoad_InBUS = 8'd0;
    rst_n = 1'b0;
    repeat (3) tick();
    obs = dut_outs();
    n_checks++;
    if (obs !== 16'h3000) begin
      n_fail++; $display("FAIL reset_hold: got %h want %h", obs, 16'h3000);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    obs = dut_outs();
    n_checks++;
    if (obs !== 16'h3000) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", obs, 16'h3000);
    end
    $display("test_reset done: outs=%h", obs);
  endtask

  task automatic test_level1_countdown();
    logic [11:0] obs, exp;
    logic [1:0]  st;
    logic [7:0]  tmr;
    start_run(2'b01, 8'd3);
    for (int c = 0; c <= 25; c++) begin
      tmr = (c < 8) ? 8'd3 : (c < 16) ? 8'd2 : (c < 24) ? 8'd1 : 8'd0;
      st  = (c == 16) ? 2'b10 : (c >= 24) ? 2'b11 : 2'b01;
      exp = {st, (c != 16), (c != 24), tmr};
      obs = dut_outs()[15:4];
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL level1_c%0d: got %h want %h", c, obs, exp);
      end
      bus_if.moveAck_InLow = (c == 16) ? 1'b0 : 1'b1;
      tick();
    end
    bus_if.moveAck_InLow = 1'b1;
    $display("test_level1_countdown done: state=%b", bus_if.state_OutBUS);
  endtask

  task automatic test_overrun();
    logic [15:0] obs, exp;
    start_run(2'b11, 8'd200);
    for (int c = 0; c <= 23; c++) begin
      if (c >= 3) begin
        exp = {(c >= 4) ? 2'b10 : 2'b01, (c < 4), 1'b1, 8'd0,
               OVR_EN ? 4'((c >= 4) ? (c - 4) / 4 : 0) : 4'd0};
        obs = dut_outs();
        obs[11:4] = 8'd0;
        n_checks++;
        if (obs !== exp) begin
          n_fail++; $display("FAIL overrun_c%0d: got %h want %h", c, obs, exp);
        end
      end
      if (c < 23) tick();
    end
    stop_to_idle();
    obs = dut_outs();
    exp = {2'b00, 1'b1, 1'b1, 8'd198, OVR_EN ? 4'd4 : 4'd0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL overrun_stop: got %h want %h", obs, exp);
    end
    $display("test_overrun done: overrun=%0d", bus_if.overrun_OutBUS);
  endtask

  task automatic test_level_switch();
    logic [2:0] obs, exp;
    start_run(2'b01, 8'd200);
    for (int c = 0; c <= 12; c++) begin
      exp = {(c == 12) ? 2'b10 : 2'b01, (c != 12)};
      obs = {bus_if.state_OutBUS, bus_if.moveReq_OutLow};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL level_switch_c%0d: got %b want %b", c, obs, exp);
      end
      if (c == 8) bus_if.level_InBUS = 2'b11;
      tick();
    end
    stop_to_idle();
    $display("test_level_switch done");
  endtask

  task automatic test_expiry_beats_move();
    logic [11:0] obs, exp;
    start_run(2'b10, 8'd1);
    for (int c = 0; c <= 9; c++) begin
      exp = {(c >= 8) ? 2'b11 : 2'b01, 1'b1, (c != 8), (c >= 8) ? 8'd0 : 8'd1};
      obs = dut_outs()[15:4];
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL expiry_vs_move_c%0d: got %h want %h", c, obs, exp);
      end
      tick();
    end
    $display("test_expiry_beats_move done");
  endtask

  task automatic test_stop_wait_ack();
    logic [15:0] obs, exp;
    start_run(2'b11, 8'd50);
    repeat (4) tick();
    obs = dut_outs();
    n_checks++;
    if (obs[15:13] !== 3'b100) begin
      n_fail++; $display("FAIL stop_pre_wait: got %b want %b", obs[15:13], 3'b100);
    end
    bus_if.stop_InLow = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      bus_if.stop_InLow = 1'b1;
      obs = dut_outs();
      exp = {2'b00, 1'b1, 1'b1, 8'd50, 4'd0};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL stop_idle_%0d: got %h want %h", c, obs, exp);
      end
    end
    start_run(2'b01, 8'd77);
    obs = dut_outs();
    exp = {2'b01, 1'b1, 1'b1, 8'd77, 4'd0};
    n_checks++;
    if (obs !== exp) begin
      n_fail++; $display("FAIL stop_reload: got %h want %h", obs, exp);
    end
    stop_to_idle();
    $display("test_stop_wait_ack done");
  endtask

  task automatic test_zero_load_and_async_reset();
    logic [15:0] obs;
    start_run(2'b01, 8'd0);
    obs = dut_outs();
    n_checks++;
    if (obs[15:4] !== {2'b11, 1'b1, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL zero_load_pulse: got %h want %h", obs[15:4], 12'hD00);
    end
    tick();
    obs = dut_outs();
    n_checks++;
    if (obs[15:4] !== {2'b11, 1'b1, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL zero_load_after: got %h want %h", obs[15:4], 12'hF00);
    end
    start_run(2'b11, 8'd100);
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== 16'h3000) begin
      n_fail++; $display("FAIL async_reset: got %h want %h", obs, 16'h3000);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    $display("test_zero_load_and_async_reset done");
  endtask

  // Reference model: scheduler rules evaluated with plain integers.
  int m_st, m_req, m_done, m_timer, m_ovr, m_presc, m_sec, m_mv;

  task automatic model_step(input bit start_n, input bit stop_n, input bit ack_n,
                            input int lvl, input int load);
    bit run_like, btick, wrap, expire, due;
    int per, old_timer;
    run_like  = (m_st == 1) || (m_st == 2);
    btick     = run_like && (m_presc == TD - 1);
    wrap      = btick && (m_sec == ST - 1);
    expire    = wrap && (m_timer <= 1);
    per       = (lvl == 2) ? L2 : (lvl == 3) ? L3 : L1;
    due       = btick && (m_mv >= per - 1);
    old_timer = m_timer;
    m_done    = 1;
    if (run_like) begin
      m_presc = btick ? 0 : m_presc + 1;
      if (btick) begin
        m_sec = wrap ? 0 : m_sec + 1;
        m_mv  = due ? 0 : m_mv + 1;
      end
      if (wrap && m_timer > 0) m_timer--;
    end
    if (!stop_n) begin
      m_st = 0; m_req = 1; m_timer = old_timer; m_presc = 0; m_sec = 0; m_mv = 0;
    end else if (!run_like) begin
      if (!start_n) begin
        m_ovr = 0;
        m_timer = load;
        if (load == 0) begin m_done = 0; m_st = 3; end
        else m_st = 1;
      end
    end else begin
      if (OVR_EN && m_st == 2 && due && !expire && m_ovr < 15) m_ovr++;
      if (expire) begin
        m_done = 0; m_req = 1; m_st = 3; m_timer = 0; m_presc = 0; m_sec = 0; m_mv = 0;
      end else if (m_st == 2 && !ack_n) begin
        m_req = 1; m_st = 1;
      end else if (m_st == 1 && due) begin
        m_req = 0; m_st = 2;
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] obs, exp;
    int lvl, load, fails_before;
    bit s, p, a, slow_ack;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    m_st = 0; m_req = 1; m_done = 1; m_timer = 0; m_ovr = 0; m_presc = 0; m_sec = 0; m_mv = 0;
    fails_before = n_fail;
    lvl = 1;
    slow_ack = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        lvl = int'($urandom_range(0, 3));
        slow_ack = ($urandom_range(0, 1) == 1);
      end
      load = int'($urandom_range(0, 6));
      s = ($urandom_range(0, 7) != 0);
      p = ($urandom_range(0, 59) != 0);
      a = slow_ack ? ($urandom_range(0, 29) != 0) : ($urandom_range(0, 3) != 0);
      bus_if.start_InLow = s; bus_if.stop_InLow = p; bus_if.moveAck_InLow = a;
      bus_if.level_InBUS = 2'(lvl); bus_if.timerLoad_InBUS = 8'(load);
      model_step(s, p, a, lvl, load);
      tick();
      obs = dut_outs();
      exp = {2'(m_st), 1'(m_req), 1'(m_done), 8'(m_timer), 4'(m_ovr)};
      n_checks++;
      if (obs !== exp) begin
        n_fail++; $display("FAIL random_c%0d: got %h want %h", c, obs, exp);
      end
    end
    bus_if.start_InLow = 1'b1; bus_if.stop_InLow = 1'b1; bus_if.moveAck_InLow = 1'b1;
    $display("test_random done: %0d new failures", n_fail - fails_before);
  endtask

  initial begin
    test_reset();
    test_level1_countdown();
    test_overrun();
    test_level_switch();
    test_expiry_beats_move();
    test_stop_wait_ack();
    test_zero_load_and_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
